bus_cycle_controller: RTL

- Peripheral-side bus-cycle sequencer for the 8088 minimum-mode bus.
- Latches the multiplexed 20-bit address on ALE and decodes one memory segment and one I/O page into chip selects.
- Drives READY with per-region programmable wait states and emits one-cycle read/write transfer strobes to the memory/IO models.
- Sits between the processor pin interface (peripheral side) and the bench's memory and I/O models.

---
 rtl/bus_cycle_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller
// Peripheral-side sequencer for the 8088 minimum-mode bus. It latches the
// multiplexed address on ALE and decodes one memory segment and one I/O page
// into chip selects. It holds READY low for each region's wait states, then
// emits a one-cycle read or write transfer strobe toward the memory/IO models.
//
// Handshake: the processor owns RD/WR. A cycle completes only after READY has
// returned high. At that point exactly one RD_STB or WR_STB pulse is issued,
// one clock after the XFER state is entered. The chip select then stays up
// until RD and WR are both seen high again. ALE always wins: it restarts
// decoding and silently discards any cycle that is still in flight.
module bus_cycle_controller #(
    parameter logic [3:0]  MEM_SEG  = 4'h0,
    parameter logic [7:0]  IO_PAGE  = 8'h80,
    parameter int unsigned WAIT_MEM = 2,
    parameter int unsigned WAIT_IO  = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic        RD,
    input  logic        WR,
    input  logic [7:0]  AD,
    input  logic [11:0] A,
    output logic [19:0] ADDR,
    output logic        CS_MEM,
    output logic        CS_IO,
    output logic        READY,
    output logic        RD_STB,
    output logic        WR_STB,
    output logic        UNMAPPED,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LATCHED = 3'd1,
        S_WAIT    = 3'd2,
        S_XFER    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    // Wait-state counts narrowed to the counter width (legal range 0..15).
    localparam logic [3:0] WAIT_MEM_CNT = 4'(WAIT_MEM);
    localparam logic [3:0] WAIT_IO_CNT  = 4'(WAIT_IO);

    state_t     state;
    logic [3:0] count;
    logic       iom_q;

    // Strobe qualification: RD/WR are active-low processor pins.
    logic rd_act;
    logic wr_act;
    logic one_strobe;
    logic both_strobes;
    logic no_strobe;

    // Region decode against the latched address and the latched IO/M.
    logic       hit_mem;
    logic       hit_io;
    logic       hit_any;
    logic [3:0] wait_sel;

    assign rd_act       = ~RD;
    assign wr_act       = ~WR;
    assign one_strobe   = rd_act ^ wr_act;
    assign both_strobes = rd_act & wr_act;
    assign no_strobe    = RD & WR;

    assign hit_mem  = ~iom_q && (ADDR[19:16] == MEM_SEG);
    assign hit_io   =  iom_q && (ADDR[15:8]  == IO_PAGE);
    assign hit_any  = hit_mem | hit_io;
    assign wait_sel = hit_mem ? WAIT_MEM_CNT : WAIT_IO_CNT;

    assign state_dbg = state;

    // Bus-cycle FSM: address latch, decode, wait-state count and strobe pulses.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            count    <= 4'd0;
            iom_q    <= 1'b0;
            ADDR     <= 20'd0;
            CS_MEM   <= 1'b0;
            CS_IO    <= 1'b0;
            READY    <= 1'b1;
            RD_STB   <= 1'b0;
            WR_STB   <= 1'b0;
            UNMAPPED <= 1'b0;
        end else begin
            // Pulse outputs last exactly one clock unless re-armed below.
            RD_STB   <= 1'b0;
            WR_STB   <= 1'b0;
            UNMAPPED <= 1'b0;

            if (ALE) begin
                // A fresh address phase aborts whatever was in progress.
                ADDR   <= {A, AD};
                iom_q  <= IOM;
                CS_MEM <= 1'b0;
                CS_IO  <= 1'b0;
                READY  <= 1'b1;
                state  <= S_LATCHED;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Strobes without a preceding ALE are ignored.
                        state <= S_IDLE;
                    end

                    S_LATCHED: begin
                        if (both_strobes || (one_strobe && !hit_any)) begin
                            UNMAPPED <= 1'b1;
                            state    <= S_HOLDOFF;
                        end else if (one_strobe) begin
                            CS_MEM <= hit_mem;
                            CS_IO  <= hit_io;
                            count  <= wait_sel;
                            if (wait_sel != 4'd0) begin
                                READY <= 1'b0;
                                state <= S_WAIT;
                            end else begin
                                state <= S_XFER;
                            end
                        end
                    end

                    S_WAIT: begin
                        if (no_strobe) begin
                            // Processor dropped the cycle early: no transfer.
                            READY <= 1'b1;
                            state <= S_HOLDOFF;
                        end else begin
                            count <= count - 4'd1;
                            if (count <= 4'd1) begin
                                READY <= 1'b1;
                                state <= S_XFER;
                            end
                        end
                    end

                    S_XFER: begin
                        if (rd_act) begin
                            RD_STB <= 1'b1;
                        end else begin
                            WR_STB <= 1'b1;
                        end
                        state <= S_HOLDOFF;
                    end

                    S_HOLDOFF: begin
                        if (no_strobe) begin
                            CS_MEM <= 1'b0;
                            CS_IO  <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Transfer strobes are mutually exclusive.
    assert property (@(posedge CLK) disable iff (!RESET) !(RD_STB && WR_STB));

    // At most one region is ever selected.
    assert property (@(posedge CLK) disable iff (!RESET) !(CS_MEM && CS_IO));

    // A miss never coexists with a chip select.
    assert property (@(posedge CLK) disable iff (!RESET) UNMAPPED |-> !(CS_MEM || CS_IO));

endmodule
